vga_plot_arbiter: RTL and testbench

Shares the single VGA adapter write port (x, y, colour, plot) between four independent drawing engines, such as stair/platform animators, a player sprite and a score painter. Each engine requests the port and holds it for a burst of pixels, for example a full rectangle erase or redraw. The arbiter grants round-robin, forwards the owner's pixel stream through one register stage, and optionally pre-empts an owner that holds the port too long.

---
 rtl/vga_plot_arbiter.sv | 170 +++++++++++++++++
 tb/tb_vga_plot_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_plot_arbiter.sv
// Round-robin arbiter sharing one VGA adapter write port among four drawing engines.
// Optional owner pre-emption after MAX_HOLD cycles: define VGA_PLOT_ARB_TIMEOUT_EN.
module vga_plot_arbiter #(
  parameter int unsigned MAX_HOLD = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [31:0] in_x,
  input  logic [27:0] in_y,
  input  logic [11:0] in_colour,
  input  logic [3:0]  in_plot,
  output logic [3:0]  grant,
  output logic [7:0]  out_x,
  output logic [6:0]  out_y,
  output logic [2:0]  out_colour,
  output logic        plot,
  output logic        busy,
  output logic        timeout
);

  typedef enum logic {
    IDLE,
    OWNED
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  grant_q, grant_d;
  logic [1:0]  last_q, last_d;
  logic [7:0]  x_q;
  logic [6:0]  y_q;
  logic [2:0]  colour_q;
  logic        plot_q;

  logic [1:0]  own_idx;
  logic [7:0]  own_x;
  logic [6:0]  own_y;
  logic [2:0]  own_colour;
  logic        own_plot;
  logic [1:0]  pick_idx;
  logic [1:0]  cand;
  logic        pick_found;

  // Legal range is 2..65535; an out-of-range value shows up as this block in the hierarchy.
  if (MAX_HOLD < 2 || MAX_HOLD > 65535) begin : g_max_hold_out_of_range
  end

  // Owner fields selected by the one-hot grant register.
  always_comb begin
    own_idx    = '0;
    own_x      = '0;
    own_y      = '0;
    own_colour = '0;
    own_plot   = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (grant_q[i]) begin
        own_idx    = 2'(i);
        own_x      = in_x[8*i +: 8];
        own_y      = in_y[7*i +: 7];
        own_colour = in_colour[3*i +: 3];
        own_plot   = in_plot[i];
      end
    end
  end

  // Scan from last+1 upward; the 2-bit add wraps, so k=4 lands back on last.
  always_comb begin
    pick_idx   = last_q;
    pick_found = 1'b0;
    cand       = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

`ifdef VGA_PLOT_ARB_TIMEOUT_EN
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic        timeout_q, timeout_d;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
`ifdef VGA_PLOT_ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = 4'b0001 << pick_idx;
          state_d = OWNED;
`ifdef VGA_PLOT_ARB_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end
      end
      OWNED: begin
        if (!req[own_idx]) begin
          grant_d = '0;
          last_d  = own_idx;
          state_d = IDLE;
        end else begin
`ifdef VGA_PLOT_ARB_TIMEOUT_EN
          if (hold_cnt_q == 16'(MAX_HOLD - 1)) begin
            grant_d   = '0;
            last_d    = own_idx;
            state_d   = IDLE;
            timeout_d = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q + 16'd1;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      last_q   <= 2'd3;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      plot_q  <= (|grant_q) & own_plot;
      if (|grant_q) begin
        x_q      <= own_x;
        y_q      <= own_y;
        colour_q <= own_colour;
      end
    end
  end

`ifdef VGA_PLOT_ARB_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign grant      = grant_q;
  assign busy       = |grant_q;
  assign out_x      = x_q;
  assign out_y      = y_q;
  assign out_colour = colour_q;
  assign plot       = plot_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Scoreboard bench for vga_plot_arbiter: a per-cycle ownership model pushes expected
// outputs into a queue; a negedge monitor pops and compares against the DUT.
module tb_vga_plot_arbiter;

`ifdef VGA_PLOT_ARB_TIMEOUT_EN
  localparam int  MH    = 8;
  localparam bit  TO_EN = 1'b1;
`else
  localparam int  MH    = 1024;
  localparam bit  TO_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] in_x;
  logic [27:0] in_y;
  logic [11:0] in_colour;
  logic [3:0]  in_plot;
  logic [3:0]  grant;
  logic [7:0]  out_x;
  logic [6:0]  out_y;
  logic [2:0]  out_colour;
  logic        plot;
  logic        busy;
  logic        timeout;

  vga_plot_arbiter #(.MAX_HOLD(MH)) dut (
    .clock(clock), .reset(reset), .req(req), .in_x(in_x), .in_y(in_y),
    .in_colour(in_colour), .in_plot(in_plot), .grant(grant), .out_x(out_x),
    .out_y(out_y), .out_colour(out_colour), .plot(plot), .busy(busy),
    .timeout(timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] grant;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   plot_seen = 0;
  int   to_seen = 0;

  // Reference model: owner index (-1 when idle), previous owner, cycles owned so far.
  int         m_owner = -1;
  int         m_last  = 3;
  int         m_held  = 0;
  logic [7:0] m_x = '0;
  logic [6:0] m_y = '0;
  logic [2:0] m_c = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endfunction

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("grant", {28'd0, grant}, {28'd0, e.grant});
      chk("busy", {31'd0, busy}, {31'd0, |e.grant});
      chk("timeout", {31'd0, timeout}, {31'd0, e.to});
      chk("plot", {31'd0, plot}, {31'd0, e.plot});
      chk("pixel", {14'd0, out_x, out_y, out_colour}, {14'd0, e.x, e.y, e.c});
      if (plot === 1'b1) plot_seen++;
      if (timeout === 1'b1) to_seen++;
    end
  end

  task automatic cycle(input logic rst, input logic [3:0] r, input logic [3:0] p,
                       input logic [31:0] xs, input logic [27:0] ys, input logic [11:0] cs);
    exp_t e;
    int   pick;
    reset = rst; req = r; in_plot = p; in_x = xs; in_y = ys; in_colour = cs;
    e.to   = 1'b0;
    e.plot = 1'b0;
    if (rst) begin
      m_owner = -1; m_last = 3; m_held = 0;
      m_x = '0; m_y = '0; m_c = '0;
    end else begin
      if (m_owner >= 0) begin
        e.plot = p[m_owner];
        m_x = xs[8*m_owner +: 8];
        m_y = ys[7*m_owner +: 7];
        m_c = cs[3*m_owner +: 3];
      end
      if (m_owner < 0) begin
        pick = -1;
        for (int k = 1; k <= 4; k++)
          if (pick < 0 && r[(m_last + k) % 4]) pick = (m_last + k) % 4;
        if (pick >= 0) begin
          m_owner = pick;
          m_held  = 1;
        end
      end else if (!r[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
      end else if (TO_EN && m_held == MH) begin
        m_last  = m_owner;
        m_owner = -1;
        e.to    = 1'b1;
      end else begin
        m_held++;
      end
    end
    e.grant = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    e.x = m_x; e.y = m_y; e.c = m_c;
    exp_q.push_back(e);
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  // Random fields everywhere, with requester k's fields overridden.
  task automatic pix(input logic [3:0] r, input logic [3:0] p, input int k,
                     input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    logic [31:0] xs;
    logic [27:0] ys;
    logic [11:0] cs;
    xs = $urandom; ys = 28'($urandom); cs = 12'($urandom);
    xs[8*k +: 8] = x;
    ys[7*k +: 7] = y;
    cs[3*k +: 3] = c;
    cycle(1'b0, r, p, xs, ys, cs);
  endtask

  int rem [4];
  int ps_before;

  initial begin
    // Reset with everyone requesting, then requester 0 wins first.
    cycle(1'b1, 4'hF, 4'hF, $urandom, 28'($urandom), 12'($urandom));
    cycle(1'b1, 4'hF, 4'hF, $urandom, 28'($urandom), 12'($urandom));
    for (int i = 0; i < 3; i++) pix(4'hF, 4'hF, 0, 8'(i), 7'(i), 3'(i));
    pix(4'hE, 4'h1, 0, 8'd7, 7'd7, 3'd7);
    for (int i = 0; i < 4; i++) pix(4'h0, 4'h0, 0, 8'd0, 7'd0, 3'd0);
    cycle(1'b1, 4'h0, 4'h0, '0, '0, '0);

    // Single burst from requester 2: 40 pixels, req dropped with the last one.
    ps_before = plot_seen;
    pix(4'b0100, 4'b0000, 2, 8'd0, 7'd60, 3'b100);
    for (int i = 0; i < 40; i++)
      pix((i == 39) ? 4'b0000 : 4'b0100, 4'b0100, 2, 8'(10 + i), 7'd60, 3'b100);
    pix(4'b0000, 4'b0000, 2, 8'd0, 7'd0, 3'd0);
    pix(4'b0000, 4'b0000, 2, 8'd0, 7'd0, 3'd0);
    chk("burst_plot_count", 32'(plot_seen - ps_before), 32'd40);

    // Round-robin: all request, each owner releases on its third cycle.
    for (int i = 0; i < 24; i++) begin
      logic [3:0] r;
      r = 4'hF;
      if (m_owner >= 0 && m_held == 3) r[m_owner] = 1'b0;
      pix(r, 4'hF, 1, 8'($urandom), 7'($urandom), 3'($urandom));
    end
    for (int i = 0; i < 3; i++) pix(4'h0, 4'h0, 0, '0, '0, '0);

    // Non-owner isolation: requester 0 owns while requester 1 plots x=200.
    cycle(1'b1, 4'h0, 4'h0, '0, '0, '0);
    for (int i = 0; i < 12; i++)
      cycle(1'b0, 4'b0011, {3'b001, (i % 3 != 0)}, {16'd0, 8'd200, 8'(i)},
            {14'd0, 7'd99, 7'(i)}, {6'd0, 3'd5, 3'(i)});
    pix(4'h0, 4'h0, 0, '0, '0, '0);

    // Long hold: requesters 0 and 1 both held high.
    cycle(1'b1, 4'h0, 4'h0, '0, '0, '0);
    to_seen = 0;
    for (int i = 0; i < 100; i++) pix(4'b0011, 4'b0011, 0, 8'(i), 7'(i), 3'(i));
    chk("timeout_seen", 32'(to_seen > 0), 32'(TO_EN));
    for (int i = 0; i < 3; i++) pix(4'h0, 4'h0, 0, '0, '0, '0);

    // Mid-burst reset during requester 3's burst, then 0 beats 3.
    pix(4'b1000, 4'b1000, 3, 8'd1, 7'd1, 3'd1);
    for (int i = 0; i < 4; i++) pix(4'b1000, 4'b1000, 3, 8'(40 + i), 7'd2, 3'd6);
    cycle(1'b1, 4'b1000, 4'b1000, $urandom, 28'($urandom), 12'($urandom));
    for (int i = 0; i < 4; i++) pix(4'b1001, 4'b1001, 3, 8'(i), 7'(i), 3'(i));
    for (int i = 0; i < 3; i++) pix(4'h0, 4'h0, 0, '0, '0, '0);

    // Randomised traffic from four burst agents with occasional reset.
    for (int i = 0; i < 4; i++) rem[i] = 0;
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] r;
      logic       rst;
      rst = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < 4; i++)
        if (rem[i] == 0 && $urandom_range(0, 7) == 0) rem[i] = $urandom_range(1, 14);
      for (int i = 0; i < 4; i++) r[i] = (rem[i] != 0);
      if (!rst && m_owner >= 0) begin
        if (rem[m_owner] == 1) begin
          r[m_owner] = 1'b0;
          rem[m_owner] = 0;
        end else if (rem[m_owner] > 1) begin
          rem[m_owner]--;
        end
      end
      cycle(rst, r, 4'($urandom), $urandom, 28'($urandom), 12'($urandom));
    end

    @(negedge clock);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog at %0t: got running expected finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
